// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: default
// Q-format widths, the controller state encoding and fixed-point helpers.
package nn_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 16;

  // Saturation helper operates on a generously wide signed value and returns
  // a 64-bit clamp; callers keep the low WIDTH bits.
  localparam int SAT_IN_W  = 160;
  localparam int SAT_OUT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Clamp v into the signed range of a w-bit word (w <= SAT_OUT_W).
  function automatic logic [SAT_OUT_W-1:0] sat_q(input logic signed [SAT_IN_W-1:0] v,
                                                  input int w);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = '0;
    for (int i = 0; i < SAT_OUT_W - 1; i++) begin
      if (i < w - 1) hi[i] = 1'b1;
    end
    lo = ~hi;
    if (v > hi) return hi[SAT_OUT_W-1:0];
    else if (v < lo) return lo[SAT_OUT_W-1:0];
    else return v[SAT_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/output_neuron_mac_if.sv
// Handshake and data bus of the output neuron: weight/bias load, hidden
// vector input and result output.
interface output_neuron_mac_if #(
  parameter int NUM_INPUT = 3,
  parameter int WIDTH     = 32
);
  logic                       wr;
  logic [NUM_INPUT*WIDTH-1:0] i_w;
  logic [WIDTH-1:0]           i_b;
  logic                       i_valid;
  logic                       i_ready;
  logic [NUM_INPUT*WIDTH-1:0] i_k;
  logic                       o_valid;
  logic                       o_ready;
  logic [WIDTH-1:0]           o;

  modport master (
    output wr, i_w, i_b, i_valid, i_k, o_ready,
    input  i_ready, o_valid, o
  );

  modport slave (
    input  wr, i_w, i_b, i_valid, i_k, o_ready,
    output i_ready, o_valid, o
  );
endinterface

// File: rtl/output_neuron_mac_mac_unit.sv
// Single shared signed multiplier feeding a wide accumulator. The
// accumulator is sized so NUM_INPUT full-width products can never overflow.
module mac_unit #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 66
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = a * b;

  // Accumulate the full-precision product; clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/output_neuron_mac.sv
// Output-layer neuron: serial MAC of the hidden vector against stored
// weights, plus bias, floored and saturated back to the Q format.
//
// state | meaning
// IDLE  | waiting; accepts weight writes or a hidden vector
// MAC   | one product accumulated per edge, NUM_INPUT edges
// FIN   | add bias, rescale, saturate into o
// DONE  | o valid, held until the consumer takes it
module output_neuron_mac
  import nn_pkg::*;
#(
  parameter int NUM_INPUT = 3,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC      = FRAC_DEF
) (
  input logic              clk,
  input logic              rst,
  output_neuron_mac_if.slave bus
);

  localparam int ACC_W = 2 * WIDTH + clog2(NUM_INPUT + 1);
  localparam int IDX_W = clog2(NUM_INPUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUT - 1);

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [NUM_INPUT*WIDTH-1:0] w_reg;
  logic [NUM_INPUT*WIDTH-1:0] k_reg;
  logic [WIDTH-1:0]           b_reg;
  logic [WIDTH-1:0]           o_reg;
  logic                       o_valid_reg;

  logic                       accept;
  logic signed [WIDTH-1:0]    k_sel;
  logic signed [WIDTH-1:0]    w_sel;
  logic signed [ACC_W-1:0]    acc;

  logic signed [ACC_W:0]      bias_ext;
  logic signed [ACC_W:0]      fin_sum;
  logic signed [ACC_W:0]      fin_shift;
  logic [SAT_OUT_W-1:0]       sat_val;
  logic [SAT_OUT_W-WIDTH-1:0] sat_unused_hi;
  logic [WIDTH-1:0]           o_next;

  // A pending write blocks acceptance so a vector never sees stale weights.
  assign bus.i_ready = (state == IDLE) && !bus.wr;
  assign accept      = bus.i_ready && bus.i_valid;
  assign bus.o       = o_reg;
  assign bus.o_valid = o_valid_reg;

  assign k_sel = k_reg[int'(idx)*WIDTH +: WIDTH];
  assign w_sel = w_reg[int'(idx)*WIDTH +: WIDTH];

  mac_unit #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == MAC),
    .a   (k_sel),
    .b   (w_sel),
    .acc (acc)
  );

  // Bias is aligned to the product scale (2*FRAC) before the single rescale,
  // so the arithmetic shift floors the complete sum exactly once.
  always_comb begin
    bias_ext  = (ACC_W+1)'($signed(b_reg)) <<< FRAC;
    fin_sum   = {acc[ACC_W-1], acc} + bias_ext;
    fin_shift = fin_sum >>> FRAC;
    sat_val   = sat_q(SAT_IN_W'(fin_shift), WIDTH);
    {sat_unused_hi, o_next} = sat_val;
  end

  // Controller, weight/bias/operand registers and output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      w_reg       <= '0;
      k_reg       <= '0;
      b_reg       <= '0;
      o_reg       <= '0;
      o_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr) begin
            w_reg <= bus.i_w;
            b_reg <= bus.i_b;
          end else if (bus.i_valid) begin
            k_reg <= bus.i_k;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= FIN;
        end
        FIN: begin
          o_reg       <= o_next;
          o_valid_reg <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.o_ready) begin
            o_valid_reg <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_neuron_mac.sv
// Directed and randomized checks of output_neuron_mac against a plain
// arithmetic reference of the Q-format neuron.
module tb_output_neuron_mac;

  localparam int N = 3;
  localparam int W = 32;
  typedef logic [N*W-1:0] vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t w_m;
  logic [W-1:0] b_m;
  logic [W-1:0] exp_o;

  output_neuron_mac_if #(.NUM_INPUT(N), .WIDTH(W)) bus ();

  output_neuron_mac #(.NUM_INPUT(N), .WIDTH(W), .FRAC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // floor((sum k*w + b*2^16) / 2^16), clamped to the 32-bit signed range
  function automatic logic [W-1:0] ref_out(input vec_t k, input vec_t w, input logic [W-1:0] b);
    logic signed [127:0] s, q, kj, wj, bb;
    s = 0;
    for (int j = 0; j < N; j++) begin
      kj = $signed(k[j*W +: W]);
      wj = $signed(w[j*W +: W]);
      s  = s + kj * wj;
    end
    bb = $signed(b);
    s  = s + bb * 65536;
    q  = s / 65536;
    if (s < 0 && (s % 65536) != 0) q = q - 1;
    if (q > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (q < -(128'sh80000000)) return 32'h80000000;
    return q[W-1:0];
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) begin
      r = $urandom;
      v[j*W +: W] = $signed(r) >>> $urandom_range(0, 16);
    end
    return v;
  endfunction

  task automatic write_wb(input vec_t w, input logic [W-1:0] b);
    @(negedge clk);
    bus.wr  = 1'b1;
    bus.i_w = w;
    bus.i_b = b;
    @(negedge clk);
    bus.wr = 1'b0;
    w_m = w;
    b_m = b;
  endtask

  // Presents k in IDLE; returns at the negedge after the accepting edge.
  task automatic send(input vec_t k);
    bus.i_k     = k;
    bus.i_valid = 1'b1;
    #1;
    chk("i_ready_at_send", 64'(bus.i_ready), 64'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_k     = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic [W-1:0] exp_val);
    int lat;
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_o"}, 64'(bus.o), 64'(exp_val));
  endtask

  task automatic handshake();
    @(negedge clk);
    chk("o_valid_drop", 64'(bus.o_valid), 64'd0);
    chk("i_ready_after", 64'(bus.i_ready), 64'd1);
  endtask

  task automatic run(input string tag, input vec_t k, input logic [W-1:0] exp_val);
    send(k);
    wait_result(tag, 4, exp_val);
    handshake();
  endtask

  initial begin
    vec_t k;
    vec_t wn;
    logic [W-1:0] bn;
    errors = 0;
    checks = 0;
    w_m = '0;
    b_m = '0;
    rst = 1'b0;
    bus.wr = 1'b0;
    bus.i_w = '0;
    bus.i_b = '0;
    bus.i_valid = 1'b0;
    bus.i_k = '0;
    bus.o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_o", 64'(bus.o), 64'd0);
    chk("reset_i_ready", 64'(bus.i_ready), 64'd1);
    rst = 1'b1;

    // functional vector: 1.0*0.5 + 2.0*0.25 - 0.5*2.0 + 1.0
    write_wb({32'h00020000, 32'h00004000, 32'h00008000}, 32'h00010000);
    run("func", {32'hFFFF8000, 32'h00020000, 32'h00010000}, 32'h00010000);

    write_wb({3{32'h7FFFFFFF}}, 32'h0);
    run("sat_pos", {3{32'h7FFFFFFF}}, 32'h7FFFFFFF);
    run("sat_neg", {3{32'h80000000}}, 32'h80000000);

    write_wb({32'h0, 32'h0, 32'h00008000}, 32'h0);
    run("floor_pos", {32'h0, 32'h0, 32'h00000001}, 32'h00000000);
    run("floor_neg", {32'h0, 32'h0, 32'hFFFFFFFF}, 32'hFFFFFFFF);

    for (int t = 0; t < 8; t++) begin
      wn = rand_vec();
      bn = $urandom;
      bn = $signed(bn) >>> $urandom_range(4, 20);
      write_wb(wn, bn);
      k = rand_vec();
      run("rand", k, ref_out(k, w_m, b_m));
    end

    // backpressure: result must hold while the consumer stalls
    bus.o_ready = 1'b0;
    k = rand_vec();
    exp_o = ref_out(k, w_m, b_m);
    send(k);
    wait_result("bp", 4, exp_o);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.o_valid), 64'd1);
      chk("bp_hold_o", 64'(bus.o), 64'(exp_o));
      chk("bp_hold_i_ready", 64'(bus.i_ready), 64'd0);
    end
    bus.o_ready = 1'b1;
    handshake();

    // write and input in the same idle cycle: write wins
    wn = rand_vec();
    bn = 32'h00030000;
    k  = rand_vec();
    bus.wr = 1'b1;
    bus.i_w = wn;
    bus.i_b = bn;
    bus.i_k = k;
    bus.i_valid = 1'b1;
    #1;
    chk("collide_i_ready", 64'(bus.i_ready), 64'd0);
    @(negedge clk);
    bus.wr = 1'b0;
    w_m = wn;
    b_m = bn;
    #1;
    chk("collide_next_ready", 64'(bus.i_ready), 64'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_result("collide", 4, ref_out(k, w_m, b_m));
    handshake();

    // write strobe mid-transaction must be ignored
    k = rand_vec();
    exp_o = ref_out(k, w_m, b_m);
    send(k);
    bus.wr = 1'b1;
    bus.i_w = rand_vec();
    bus.i_b = $urandom;
    @(negedge clk);
    bus.wr = 1'b0;
    wait_result("wr_in_mac", 3, exp_o);
    handshake();
    k = rand_vec();
    run("wr_readback", k, ref_out(k, w_m, b_m));

    // reset at the second MAC edge aborts and clears weights
    k = rand_vec();
    send(k);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mac_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_mac_i_ready", 64'(bus.i_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    w_m = '0;
    b_m = '0;
    run("after_reset", rand_vec(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_neuron_mac.md
Name: output_neuron_mac

Overview:
- Output-layer neuron that consumes the packed hidden-layer result bus and produces one fixed-point output per transaction.
- Performs a serial multiply-accumulate over NUM_INPUT hidden activations against locally stored weights, then adds a bias.
- Uses one shared multiplier in place of a parallel multiplier array, which trades latency for area.
- Valid/ready handshake on both sides so it can sit between the hidden layer and the error/backprop stage.

Parameters:
- NUM_INPUT, 3: number of hidden-layer values consumed, equal to the hidden layer's NUM_PCTN.
- WIDTH, 32: signed two's-complement width of every activation, weight, bias and output.
- FRAC, 16: fractional bits of the Q format, shared by all operands.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wr  in  1  weight/bias write strobe.
- i_w  in  NUM_INPUT*WIDTH  weights; slice j = bits [j*WIDTH +: WIDTH].
- i_b  in  WIDTH  bias.
- i_valid  in  1  i_k holds a valid hidden-layer vector.
- i_ready  out  1  block can accept i_k this cycle.
- i_k  in  NUM_INPUT*WIDTH  hidden activations; slice j pairs with weight slice j.
- o_valid  out  1  o holds a result.
- o_ready  in  1  consumer accepts o.
- o  out  WIDTH  signed Q result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; weight registers, bias register, accumulator, index, operand register and o all cleared to 0.
  - o_valid=0.
- States: IDLE, MAC, FIN, DONE.
- i_ready = (state==IDLE) & ~wr.
- Weight/bias writes:
  - wr=1 in IDLE: latch i_w and i_b on the next edge.
  - wr outside IDLE is ignored; weights never change mid-transaction.
- IDLE:
  - On an edge where i_valid & i_ready, capture i_k into the operand register, clear the accumulator, set idx=0, go to MAC.
- MAC:
  - Each edge: acc += k[idx]*w[idx] (full 2*WIDTH-bit signed product, no truncation); idx++.
  - On the edge that accumulates idx==NUM_INPUT-1, go to FIN.
  - Exactly NUM_INPUT MAC edges.
- Accumulator width: ACC_W = 2*WIDTH + clog2(NUM_INPUT+1). It must never overflow internally.
- FIN, one edge:
  - o <= sat((acc + (sign-extended bias << FRAC)) >>> FRAC).
  - The shift is arithmetic, so the result is rounded toward negative infinity (floor).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - o_valid <= 1; go to DONE.
- DONE:
  - o and o_valid are held stable while o_ready=0.
  - On an edge with o_ready=1: o_valid <= 0, go to IDLE. o retains its last value.
- Latency: o_valid rises NUM_INPUT+1 edges after the accepting edge. The next accept can occur no earlier than the edge after the o handshake.
- Throughput: one result per NUM_INPUT+3 cycles with o_ready tied high.
- Boundary conditions:
  - i_valid while busy: not accepted (i_ready=0); upstream must hold.
  - wr and i_valid in the same IDLE cycle: write wins, input not accepted. The next cycle the input is accepted using the new weights.
  - Reset mid-MAC or in DONE: immediate abort to IDLE, o_valid=0, no partial result ever emitted.
  - i_k changing after the accept edge has no effect on the result.

Decomposition:
- Shared package nn_pkg:
  - WIDTH/FRAC defaults;
  - state encoding localparams (IDLE=0, MAC=1, FIN=2, DONE=3);
  - clog2 constant function;
  - saturate function sat_q(acc) → WIDTH bits.
- One natural sub-module, mac_unit: the signed multiplier plus ACC_W accumulator with clear/enable. The FSM, registers and handshake stay in the top.

Test Plan:
- Functional result: NUM_INPUT=3, FRAC=16.
  - Write w={0x00008000,0x00004000,0x00020000} (0.5, 0.25, 2.0) and b=0x00010000.
  - Send k={0x00010000,0x00020000,0xFFFF8000} → o=0x00010000.
  - o_valid rises 4 edges after accept.
- Saturation:
  - All k=w=0x7FFFFFFF, b=0 → o=0x7FFFFFFF.
  - k=0x80000000, w=0x7FFFFFFF for all, b=0 → o=0x80000000.
- Floor rounding, b=0, other lanes zero:
  - k0=0x00000001, w0=0x00008000 → o=0x00000000.
  - k0=0xFFFFFFFF, w0=0x00008000 → o=0xFFFFFFFF.
- Backpressure:
  - Hold o_ready=0 for 5 cycles after o_valid → o and o_valid stable, i_ready=0 throughout.
  - o_ready=1 → o_valid falls next edge, i_ready=1 the following cycle.
- Write/accept collision:
  - wr=1 and i_valid=1 in the same IDLE cycle → i_ready=0, weights updated.
  - Input accepted next cycle; result uses the new weights.
  - wr pulsed during MAC → weights unchanged (readback via a second transaction).
- Reset mid-MAC: drive rst=0 for one cycle at the second MAC edge.
  - o_valid=0 and i_ready=1 immediately.
  - Weights read back as 0, so the next transaction with b=0 gives o=0.
